// File: rtl/instr_queue_pkg.sv
// Shared definitions for the instruction queue and its fcu/decoder/biu neighbours.
package instr_queue_pkg;

    localparam int INSTR_W   = 32;
    localparam int BUS_W     = 16;
    localparam int IQ_DEPTH  = 4;
    localparam int IQ_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2
    } iq_state_e;

endpackage

// File: rtl/iq_fifo.sv
// Generic circular buffer with push, pop, synchronous clear and occupancy count.
module iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A pop on an empty buffer is dropped; a push on a full one only lands if a pop frees a slot.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PW'(1);
            if (do_pop)  head_d = head_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem[head_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/instr_queue.sv
// Prefetch queue: fetches halfword pairs from the bus unit and presents 32-bit instructions.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int ADDR_W = IQ_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_addr,
    output logic                   fetch_req,
    output logic [ADDR_W-1:0]      fetch_address,
    input  logic                   fetch_ack,
    input  logic [BUS_W-1:0]       bus,
    output logic [INSTR_W-1:0]     ir,
    output logic                   ir_valid,
    input  logic                   ir_pop,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    iq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [BUS_W-1:0]  low_q, low_d;
    logic              push, pop_ok;
    logic [CW-1:0]     post_count;

    assign ir_valid = (count != '0);
    assign pop_ok   = ir_pop && ir_valid && !flush;

    // Occupancy as it will be after a push on this edge, including any simultaneous pop.
    assign post_count = count + CW'(1) - CW'(pop_ok);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        low_d   = low_q;
        push    = 1'b0;
        if (flush) begin
            state_d = FETCH_LO;
            pc_d    = flush_addr;
            low_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < CW'(DEPTH)) state_d = FETCH_LO;
                end
                FETCH_LO: begin
                    if (fetch_ack) begin
                        low_d   = bus;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (fetch_ack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = (post_count < CW'(DEPTH)) ? FETCH_LO : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            low_q   <= low_d;
        end
    end

    // The request is a decode of the state register, so reset drops it without a clock.
    assign fetch_req     = (state_q != IDLE);
    assign fetch_address = pc_q;

    iq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop_ok),
        .wdata ({bus, low_q}),
        .rdata (ir),
        .count (count)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a simple halfword memory model on the bus.
module tb_instr_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] flush_addr;
    logic        fetch_req;
    logic [15:0] fetch_address;
    logic        fetch_ack;
    logic [15:0] bus;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_pop;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    instr_queue #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .flush_addr    (flush_addr),
        .fetch_req     (fetch_req),
        .fetch_address (fetch_address),
        .fetch_ack     (fetch_ack),
        .bus           (bus),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_pop        (ir_pop),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 0 -> 1111, 1 -> 2222, otherwise C000 | addr[11:0].
    function automatic logic [15:0] bus_val(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1111;
        if (a == 16'h0001) return 16'h2222;
        return 16'hC000 | {4'h0, a[11:0]};
    endfunction

    assign bus = bus_val(fetch_address);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        flush_addr = 16'h0000;
        fetch_ack  = 1'b0;
        ir_pop     = 1'b0;

        step();
        step();
        chk("rst_req",   32'(fetch_req), 32'd0);
        chk("rst_valid", 32'(ir_valid),  32'd0);
        chk("rst_ir",    ir,             32'h0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_addr",  32'(fetch_address), 32'h0);

        // Fill from address 0 with an ack every cycle.
        reset     = 1'b1;
        fetch_ack = 1'b1;
        step();
        chk("fill_req1",  32'(fetch_req),     32'd1);
        chk("fill_addr1", 32'(fetch_address), 32'h0000);
        step();
        chk("fill_addr2", 32'(fetch_address), 32'h0001);
        chk("fill_nv2",   32'(ir_valid),      32'd0);
        step();
        chk("fill_ir",    ir,                 32'h22221111);
        chk("fill_v3",    32'(ir_valid),      32'd1);
        chk("fill_cnt3",  32'(count),         32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("full_cnt",   32'(count),         32'd4);
        chk("full_req",   32'(fetch_req),     32'd0);
        step();
        chk("full_hold",  32'(count),         32'd4);
        chk("full_req2",  32'(fetch_req),     32'd0);

        // Single pop from a full queue.
        ir_pop = 1'b1;
        step();
        ir_pop    = 1'b0;
        fetch_ack = 1'b0;
        chk("pop_cnt",    32'(count),         32'd3);
        chk("pop_ir",     ir,                 32'hC003C002);
        chk("pop_req0",   32'(fetch_req),     32'd0);
        step();
        chk("refill_req", 32'(fetch_req),     32'd1);
        chk("refill_adr", 32'(fetch_address), 32'h0008);
        step();
        chk("hold_req",   32'(fetch_req),     32'd1);
        chk("hold_adr",   32'(fetch_address), 32'h0008);

        // Flush (with ack and pop ignored), then pop every cycle with continuous acks.
        flush      = 1'b1;
        flush_addr = 16'h0100;
        fetch_ack  = 1'b1;
        ir_pop     = 1'b1;
        step();
        flush = 1'b0;
        chk("fl1_cnt",    32'(count),         32'd0);
        chk("fl1_adr",    32'(fetch_address), 32'h0100);
        step();
        chk("osc_cnt0",   32'(count),         32'd0);
        step();
        chk("osc_cnt1",   32'(count),         32'd1);
        chk("osc_ir1",    ir,                 32'hC101C100);
        step();
        chk("osc_cnt2",   32'(count),         32'd0);
        step();
        chk("osc_cnt3",   32'(count),         32'd1);
        chk("osc_ir3",    ir,                 32'hC103C102);
        ir_pop = 1'b0;
        step();
        chk("pre_fl_cnt", 32'(count),         32'd1);
        chk("pre_fl_adr", 32'(fetch_address), 32'h0105);

        // Flush in FETCH_HI together with an ack.
        flush      = 1'b1;
        flush_addr = 16'h0040;
        step();
        flush = 1'b0;
        chk("fl2_cnt",    32'(count),         32'd0);
        chk("fl2_adr",    32'(fetch_address), 32'h0040);
        chk("fl2_req",    32'(fetch_req),     32'd1);
        step();
        chk("fl2_nv",     32'(ir_valid),      32'd0);
        chk("fl2_adr2",   32'(fetch_address), 32'h0041);
        step();
        chk("fl2_v",      32'(ir_valid),      32'd1);
        chk("fl2_ir",     ir,                 32'hC041C040);

        // Address wrap across FFFF.
        flush      = 1'b1;
        flush_addr = 16'hFFFF;
        step();
        flush = 1'b0;
        chk("wrap_adr0",  32'(fetch_address), 32'hFFFF);
        chk("wrap_cnt0",  32'(count),         32'd0);
        step();
        chk("wrap_adr1",  32'(fetch_address), 32'h0000);
        step();
        chk("wrap_ir",    ir,                 32'h1111CFFF);
        chk("wrap_adr2",  32'(fetch_address), 32'h0001);
        chk("wrap_req",   32'(fetch_req),     32'd1);

        // Asynchronous reset in the middle of a pending request.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   32'(fetch_req),     32'd0);
        chk("arst_valid", 32'(ir_valid),      32'd0);
        chk("arst_ir",    ir,                 32'h0);
        chk("arst_cnt",   32'(count),         32'd0);
        step();
        reset = 1'b1;
        step();
        chk("restart_req", 32'(fetch_req),     32'd1);
        chk("restart_adr", 32'(fetch_address), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of 32-bit instruction entries (power of two, >=2).
REQ-002 Parameter ADDR_W, default 16: fetch address width.
REQ-003 Reset behaviour is fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port list:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard queue contents and restart fetching at flush_addr.
- flush_addr  in  ADDR_W  new fetch address, sampled when flush=1.
- fetch_req  out  1  request one 16-bit word from the bus interface unit.
- fetch_address  out  ADDR_W  word address of the current request.
- fetch_ack  in  1  bus word valid on bus this cycle; completes the request.
- bus  in  16  fetched halfword.
- ir  out  32  head instruction; {high halfword, low halfword}.
- ir_valid  out  1  queue non-empty; ir is meaningful.
- ir_pop  in  1  decoder consumes head entry this cycle.
- count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-005 FSM states: IDLE, FETCH_LO, FETCH_HI.
REQ-006 IDLE -> FETCH_LO when count < DEPTH and flush=0; otherwise stay in IDLE.
REQ-007 In FETCH_LO and FETCH_HI: fetch_req=1, fetch_address=pc; in IDLE: fetch_req=0.
REQ-008 fetch_req stays high until fetch_ack; the request is never withdrawn except by flush or reset.
REQ-009 FETCH_LO with fetch_ack: capture bus into a low-halfword register, pc <= pc+1, go to FETCH_HI.
REQ-010 FETCH_HI with fetch_ack: write {bus, low} to the tail entry, pc <= pc+1, go to FETCH_LO if post-write count < DEPTH, else go to IDLE.
REQ-011 pc wraps modulo 2^ADDR_W (16'hFFFF+1 = 16'h0000).
REQ-012 ir is driven combinationally from the head entry; ir_valid = (count != 0).
REQ-013 A written entry becomes visible on ir/ir_valid in the cycle after the FETCH_HI ack edge.
REQ-014 ir_pop with ir_valid=1 advances the head on the next edge; ir_pop with ir_valid=0 is ignored.
REQ-015 Same-cycle push and pop: count is unchanged and both pointers advance.
REQ-016 Full queue: no request is issued and the FSM waits in IDLE until a pop frees an entry.
REQ-017 Pointers are log2(DEPTH) bits wide and wrap naturally.
REQ-018 flush=1 (highest priority) has the following effect at the next edge:
- count, head and tail are set to 0;
- pc is set to flush_addr;
- state is set to FETCH_LO;
- any fetch_ack and ir_pop in the same cycle are ignored and a partial low halfword is discarded.
REQ-019 Flush-to-first-ir_valid latency with single-cycle acks: 3 cycles.

Reset
REQ-020 While reset=0, the following values are held:
- state=IDLE, pc=0, head=tail=count=0;
- low register=0;
- fetch_req=0, ir_valid=0, ir=0.
REQ-021 Reset mid-fetch abandons the request immediately (fetch_req falls asynchronously); storage array contents need not be cleared.
REQ-022 After reset deassertion, the first edge moves IDLE -> FETCH_LO and fetching starts at address 0.

Structure
REQ-023 The shared package holds:
- the state encoding constants;
- instruction width 32 and bus width 16;
- DEPTH/ADDR_W defaults, also used by the fcu/decoder/biu integration.
REQ-024 One sub-module, iq_fifo: a generic DEPTH x 32 circular buffer with push/pop/clear and count; the FSM and pc remain in instr_queue.

Verification
REQ-025 Reset, then acks every cycle with bus=16'h1111 at address 0 and 16'h2222 at address 1, no pops -> ir=32'h22221111 and ir_valid=1 three edges after reset release; after 8 acks count=4 and fetch_req=0.
REQ-026 Full queue (count=4), then single ir_pop -> count=3, then fetch_req=1 at fetch_address=16'h0008 on the next cycle.
REQ-027 ir_pop every cycle with continuous acks -> count oscillates 0/1 without underflow, and ir_pop while ir_valid=0 leaves count=0.
REQ-028 flush with flush_addr=16'h0040 asserted in FETCH_HI together with fetch_ack -> count=0, that ack is discarded, next fetch_address=16'h0040, and the first ir contains words 0x40/0x41.
REQ-029 flush_addr=16'hFFFF with two acks -> fetch_address sequence FFFF, 0000, and the entry assembles correctly.
REQ-030 reset asserted mid-request with fetch_ack pending -> fetch_req=0 and ir_valid=0 immediately, without waiting for a clock edge.
